// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_out
// Description : Raster scan generator and VGA output stage (640x480 @ 60 Hz by
//               default). Issues a bottom-origin pixel address to the frame
//               compositor and captures the compositor's registered {B,G,R}
//               pixel one cycle later. Sync pulses are delayed to match that
//               pixel pipeline.
// Ports       : vga_clk     - pixel clock
//               clrn        - asynchronous active-low reset
//               d_in_BGR    - {B,G,R} pixel for the address of the previous cycle
//               X_Addr      - column, 0 = left (0 outside the active area)
//               Y_Addr      - row, 0 = bottom line (0 outside the active area)
//               r, g, b     - registered colour outputs
//               hs, vs      - active-low sync outputs
//               frame_tick  - one-cycle pulse while the counters sit at {0,0}
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [11:0] d_in_BGR,
    output logic [9:0]  X_Addr,
    output logic [8:0]  Y_Addr,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_tick
);

    // Line layout: sync, back porch, active, front porch (same for frames).
    localparam int         c_H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int         c_V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [9:0] c_H_MAX       = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_MAX       = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] c_V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] c_H_ACT_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] c_V_ACT_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    // Last active line maps to row 0, so the row is (last line - v_cnt).
    localparam logic [8:0] c_V_ACT_LAST  = 9'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_act1;
    logic        r_hs;
    logic        r_vs;
    logic [11:0] r_bgr;
    logic        r_frame_tick;

    logic        w_h_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_act0;
    logic        w_hs0;
    logic        w_vs0;
    logic [9:0]  w_x_addr;
    logic [8:0]  w_y_addr;

    // Next-count logic. ">=" / ">" comparisons make any out-of-range count
    // fall back to 0 on the following edge.
    always_comb begin
        w_h_wrap = (r_h_cnt >= c_H_MAX);
        w_h_next = w_h_wrap ? 10'd0 : (r_h_cnt + 10'd1);
        w_v_next = r_v_cnt;
        if (r_v_cnt > c_V_MAX) begin
            w_v_next = 10'd0;
        end else if (w_h_wrap) begin
            w_v_next = (r_v_cnt == c_V_MAX) ? 10'd0 : (r_v_cnt + 10'd1);
        end
    end

    always_comb begin
        w_act0 = (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END) &&
                 (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
        w_hs0  = (r_h_cnt >= c_H_SYNC_END);
        w_vs0  = (r_v_cnt >= c_V_SYNC_END);
        // Row subtraction done modulo 2^9: the low 9 bits of the 10-bit
        // difference only depend on the low 9 bits of the operands.
        w_x_addr = 10'd0;
        w_y_addr = 9'd0;
        if (w_act0) begin
            w_x_addr = r_h_cnt - c_H_ACT_START;
            w_y_addr = c_V_ACT_LAST - r_v_cnt[8:0];
        end
    end

    // Raster counters and frame tick
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_h_cnt      <= 10'd0;
            r_v_cnt      <= 10'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_h_cnt      <= w_h_next;
            r_v_cnt      <= w_v_next;
            r_frame_tick <= (w_h_next == 10'd0) && (w_v_next == 10'd0);
        end
    end

    // Two-stage output pipeline. Stage 1 lines up with the compositor's
    // register; stage 2 captures the pixel, so sync and colour stay aligned.
    // Syncs reset high so no pulse appears before the pipeline has filled.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_act1 <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_bgr  <= 12'd0;
        end else begin
            r_hs1  <= w_hs0;
            r_vs1  <= w_vs0;
            r_act1 <= w_act0;
            r_hs   <= r_hs1;
            r_vs   <= r_vs1;
            // Pixel data is ignored outside the active window so blanking
            // is always black whatever the compositor drives.
            r_bgr  <= r_act1 ? d_in_BGR : 12'd0;
        end
    end

    assign X_Addr     = w_x_addr;
    assign Y_Addr     = w_y_addr;
    assign b          = r_bgr[11:8];
    assign g          = r_bgr[7:4];
    assign r          = r_bgr[3:0];
    assign hs         = r_hs;
    assign vs         = r_vs;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
